// File: rtl/risc16_pkg.sv
// Shared RISC-16 core definitions: datapath widths, fetch FSM encoding and
// the fetch PC used out of reset.
package risc16_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Instruction memory read port plus the decode-facing valid/ready instruction
// stream; master is the fetch controller, slave is the memory/decode side.
interface imem_fetch_ctrl_if
   import risc16_pkg::*;
#(
   parameter int ADDR_W = risc16_pkg::ADDR_W,
   parameter int DATA_W = risc16_pkg::DATA_W
);

   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output imem_en, imem_addr, instr_valid, instr_data, instr_pc,
      input  imem_rdata, instr_ready
   );

   modport slave (
      input  imem_en, imem_addr, instr_valid, instr_data, instr_pc,
      output imem_rdata, instr_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction, pc} words between the memory return path
// and decode. Flush dominates push and pop in the same cycle.
module fetch_queue
   import risc16_pkg::*;
#(
   parameter int WIDTH = risc16_pkg::DATA_W + risc16_pkg::ADDR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] slot [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && (count != 2'd0) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

   // Storage is not reset; the head is forced to zero whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (do_push) slot[wr_ptr] <= din;
   end

   assign head = (count != 2'd0) ? slot[rd_ptr] : '0;

   a_no_push_full : assert property (
      @(posedge clk) disable iff (!rst_n) do_push |-> (count != 2'd2)
   );

endmodule

// File: rtl/imem_fetch_ctrl.sv
// RISC-16 instruction fetch sequencer: owns the fetch PC, issues reads to the
// synchronous instruction memory and queues returned words for decode.
module imem_fetch_ctrl
   import risc16_pkg::*;
#(
   parameter int                ADDR_W   = risc16_pkg::ADDR_W,
   parameter int                DATA_W   = risc16_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = risc16_pkg::RESET_PC,
   parameter int                Q_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  redirect_valid,
   input  logic [ADDR_W-1:0]     redirect_pc,
   imem_fetch_ctrl_if.master     bus,
   output logic [1:0]            fetch_state
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] issued_pc_p1;
   logic              inflight;
   logic [1:0]        q_count;
   logic              accept;
   logic              issue;
   logic              push;
   logic [DATA_W+ADDR_W-1:0] q_head;

   assign accept = bus.instr_valid && bus.instr_ready;

   // A pop this cycle frees a slot, so issuing against a full pipeline is
   // still safe and sustains one instruction per cycle.
   assign issue = (state == ST_RUN) && !halt_req && !redirect_valid &&
                  ((({1'b0, q_count} + {2'b00, inflight}) < 3'(Q_DEPTH)) || accept);

   // A read returning during a redirect belongs to the old stream and is dropped.
   assign push = inflight && !redirect_valid;

   assign bus.imem_en   = issue;
   assign bus.imem_addr = fetch_pc;
   assign fetch_state   = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (redirect_valid)
            fetch_pc <= redirect_pc;
         else if (issue)
            fetch_pc <= fetch_pc + ADDR_W'(1);
         case (state)
            ST_IDLE: if (start && !halt_req) state <= ST_RUN;
            ST_RUN:  if (halt_req)           state <= ST_HALT;
            ST_HALT: if (start && !halt_req) state <= ST_RUN;
            default:                         state <= ST_IDLE;
         endcase
      end
   end

   // Stage p1: address of the word the memory returns this cycle.
   always_ff @(posedge clk) begin
      if (issue) issued_pc_p1 <= fetch_pc;
   end

   fetch_queue #(
      .WIDTH (DATA_W + ADDR_W)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (accept),
      .din   ({bus.imem_rdata, issued_pc_p1}),
      .count (q_count),
      .head  (q_head)
   );

   assign bus.instr_valid = (q_count != 2'd0);
   assign bus.instr_data  = q_head[DATA_W+ADDR_W-1:ADDR_W];
   assign bus.instr_pc    = q_head[ADDR_W-1:0];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: start, backpressure, redirect, PC wrap,
// halt/resume and asynchronous reset, against a synchronous-read memory model.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        halt_req;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [1:0]  fetch_state;
   logic [15:0] mem [65536];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   imem_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus),
      .fetch_state    (fetch_state)
   );

   always @(posedge clk) begin
      if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
   end

   function automatic logic [15:0] mdat(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h1111;
         16'h0001: return 16'h2222;
         16'h0002: return 16'h3333;
         16'h0003: return 16'h4444;
         default:  return a ^ 16'hC3A5;
      endcase
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 16'h0000; bus.instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Leaves the bench at the sample point of the first RUN cycle.
   task automatic run_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 16'h0000; bus.instr_ready = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL rst_en got %b want 0", bus.imem_en); end
      n_cmp++; if (bus.imem_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_addr got %h want 0000", bus.imem_addr); end
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.instr_valid); end
      n_cmp++; if (bus.instr_data !== 16'h0000) begin n_bad++; $display("FAIL rst_data got %h want 0000", bus.instr_data); end
      n_cmp++; if (bus.instr_pc !== 16'h0000) begin n_bad++; $display("FAIL rst_pc got %h want 0000", bus.instr_pc); end
      n_cmp++; if (fetch_state !== 2'b00) begin n_bad++; $display("FAIL rst_state got %b want 00", fetch_state); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [15:0] exp_d [4];
      exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      do_reset();
      bus.instr_ready = 1'b1;
      @(negedge clk); start = 1'b1; #1;
      n_cmp++; if (fetch_state !== 2'b00) begin n_bad++; $display("FAIL strm_idle_state got %b want 00", fetch_state); end
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL strm_idle_en got %b want 0", bus.imem_en); end
      @(negedge clk); start = 1'b0; #1;
      n_cmp++; if (fetch_state !== 2'b01) begin n_bad++; $display("FAIL strm_run_state got %b want 01", fetch_state); end
      n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_bad++; $display("FAIL strm_c0_issue got en=%b addr=%h want en=1 addr=0000", bus.imem_en, bus.imem_addr); end
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL strm_c0_valid got %b want 0", bus.instr_valid); end
      @(negedge clk); #1;
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL strm_c1_valid got %b want 0", bus.instr_valid); end
      n_cmp++; if (bus.imem_addr !== 16'h0001) begin n_bad++; $display("FAIL strm_c1_addr got %h want 0001", bus.imem_addr); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(k) || bus.instr_data !== exp_d[k]) begin
            n_bad++; $display("FAIL strm_word%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, bus.instr_valid, bus.instr_pc, bus.instr_data, 16'(k), exp_d[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.instr_ready = 1'b1;
      run_start();
      repeat (6) begin @(negedge clk); #1; end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); bus.instr_ready = 1'b0; #1;
         n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL bp_stall%0d_en got %b want 0", k, bus.imem_en); end
         n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0005 || bus.instr_data !== mdat(16'h0005)) begin
            n_bad++; $display("FAIL bp_stall%0d_head got v=%b pc=%h d=%h want v=1 pc=0005 d=%h", k, bus.instr_valid, bus.instr_pc, bus.instr_data, mdat(16'h0005));
         end
      end
      @(negedge clk); bus.instr_ready = 1'b1; #1;
      n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0007) begin n_bad++; $display("FAIL bp_resume_issue got en=%b addr=%h want en=1 addr=0007", bus.imem_en, bus.imem_addr); end
      for (int k = 0; k < 6; k++) begin
         if (k != 0) begin @(negedge clk); #1; end
         n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(5 + k) || bus.instr_data !== mdat(16'(5 + k))) begin
            n_bad++; $display("FAIL bp_drain%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, bus.instr_valid, bus.instr_pc, bus.instr_data, 16'(5 + k), mdat(16'(5 + k)));
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      bus.instr_ready = 1'b1;
      run_start();
      repeat (6) begin @(negedge clk); #1; end
      repeat (2) begin @(negedge clk); bus.instr_ready = 1'b0; #1; end
      @(negedge clk); bus.instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100; #1;
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL redir_full_en got %b want 0", bus.imem_en); end
      @(negedge clk); redirect_valid = 1'b0; #1;
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush_valid got %b want 0", bus.instr_valid); end
      n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0100) begin n_bad++; $display("FAIL redir_target_issue got en=%b addr=%h want en=1 addr=0100", bus.imem_en, bus.imem_addr); end
      @(negedge clk); #1;
      n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0101) begin n_bad++; $display("FAIL redir_c11 got v=%b addr=%h want v=0 addr=0101", bus.instr_valid, bus.imem_addr); end
      @(negedge clk); #1;
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0100 || bus.instr_data !== mdat(16'h0100)) begin
         n_bad++; $display("FAIL redir_first got v=%b pc=%h d=%h want v=1 pc=0100 d=%h", bus.instr_valid, bus.instr_pc, bus.instr_data, mdat(16'h0100));
      end
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 16'h0200; #1;
      n_cmp++; if (bus.instr_pc !== 16'h0101 || bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL redir2_cycle got pc=%h en=%b want pc=0101 en=0", bus.instr_pc, bus.imem_en); end
      @(negedge clk); redirect_valid = 1'b0; #1;
      n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0200) begin n_bad++; $display("FAIL redir2_squash got v=%b addr=%h want v=0 addr=0200", bus.instr_valid, bus.imem_addr); end
      @(negedge clk); #1;
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir2_gap got %b want 0", bus.instr_valid); end
      @(negedge clk); #1;
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0200 || bus.instr_data !== mdat(16'h0200)) begin
         n_bad++; $display("FAIL redir2_first got v=%b pc=%h d=%h want v=1 pc=0200 d=%h", bus.instr_valid, bus.instr_pc, bus.instr_data, mdat(16'h0200));
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_pc [4];
      exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      do_reset();
      bus.instr_ready = 1'b1;
      run_start();
      repeat (2) begin @(negedge clk); #1; end
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 16'hFFFE; #1;
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL wrap_redir_en got %b want 0", bus.imem_en); end
      @(negedge clk); redirect_valid = 1'b0; #1;
      n_cmp++; if (bus.imem_addr !== 16'hFFFE || bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_c4 got addr=%h v=%b want addr=fffe v=0", bus.imem_addr, bus.instr_valid); end
      @(negedge clk); #1;
      n_cmp++; if (bus.imem_addr !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_c5_addr got %h want ffff", bus.imem_addr); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         if (k == 0) begin
            n_cmp++; if (bus.imem_addr !== 16'h0000) begin n_bad++; $display("FAIL wrap_addr_roll got %h want 0000", bus.imem_addr); end
         end
         n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc[k] || bus.instr_data !== mdat(exp_pc[k])) begin
            n_bad++; $display("FAIL wrap_word%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, bus.instr_valid, bus.instr_pc, bus.instr_data, exp_pc[k], mdat(exp_pc[k]));
         end
      end
   endtask

   task automatic test_halt();
      do_reset();
      bus.instr_ready = 1'b1;
      run_start();
      repeat (4) begin @(negedge clk); #1; end
      @(negedge clk); halt_req = 1'b1; #1;
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL halt_req_en got %b want 0", bus.imem_en); end
      n_cmp++; if (bus.instr_pc !== 16'h0003 || fetch_state !== 2'b01) begin n_bad++; $display("FAIL halt_req_cycle got pc=%h st=%b want pc=0003 st=01", bus.instr_pc, fetch_state); end
      @(negedge clk); halt_req = 1'b0; #1;
      n_cmp++; if (fetch_state !== 2'b10) begin n_bad++; $display("FAIL halt_state got %b want 10", fetch_state); end
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0004 || bus.instr_data !== mdat(16'h0004)) begin
         n_bad++; $display("FAIL halt_drain got v=%b pc=%h d=%h want v=1 pc=0004 d=%h", bus.instr_valid, bus.instr_pc, bus.instr_data, mdat(16'h0004));
      end
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL halt_en got %b want 0", bus.imem_en); end
      @(negedge clk); #1;
      n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL halt_empty got v=%b en=%b want v=0 en=0", bus.instr_valid, bus.imem_en); end
      @(negedge clk); start = 1'b1; #1;
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL halt_start_en got %b want 0", bus.imem_en); end
      @(negedge clk); start = 1'b0; #1;
      n_cmp++; if (fetch_state !== 2'b01 || bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0005) begin
         n_bad++; $display("FAIL halt_resume got st=%b en=%b addr=%h want st=01 en=1 addr=0005", fetch_state, bus.imem_en, bus.imem_addr);
      end
      repeat (2) begin @(negedge clk); #1; end
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0005 || bus.instr_data !== mdat(16'h0005)) begin
         n_bad++; $display("FAIL halt_resume_word got v=%b pc=%h d=%h want v=1 pc=0005 d=%h", bus.instr_valid, bus.instr_pc, bus.instr_data, mdat(16'h0005));
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.instr_ready = 1'b1;
      run_start();
      repeat (4) begin @(negedge clk); #1; end
      n_cmp++; if (bus.instr_pc !== 16'h0002) begin n_bad++; $display("FAIL arst_pre_pc got %h want 0002", bus.instr_pc); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.imem_en !== 1'b0 || bus.imem_addr !== 16'h0000) begin n_bad++; $display("FAIL arst_mem got en=%b addr=%h want en=0 addr=0000", bus.imem_en, bus.imem_addr); end
      n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr_data !== 16'h0000 || bus.instr_pc !== 16'h0000) begin
         n_bad++; $display("FAIL arst_out got v=%b d=%h pc=%h want v=0 d=0000 pc=0000", bus.instr_valid, bus.instr_data, bus.instr_pc);
      end
      n_cmp++; if (fetch_state !== 2'b00) begin n_bad++; $display("FAIL arst_state got %b want 00", fetch_state); end
      @(negedge clk); rst_n = 1'b1;
      run_start();
      n_cmp++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_bad++; $display("FAIL arst_restart got en=%b addr=%h want en=1 addr=0000", bus.imem_en, bus.imem_addr); end
      repeat (2) begin @(negedge clk); #1; end
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000 || bus.instr_data !== 16'h1111) begin
         n_bad++; $display("FAIL arst_first got v=%b pc=%h d=%h want v=1 pc=0000 d=1111", bus.instr_valid, bus.instr_pc, bus.instr_data);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = mdat(16'(i));
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
